// File: rtl/cla_sub32_pipe_if.sv
// Operand/result bus for the pipelined CLA subtractor.
// The `sub` select exists only when CLA_SUB_ADD_MODE_EN is defined.
interface cla_sub32_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bi;
`ifdef CLA_SUB_ADD_MODE_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] d;
  logic             bo;
  logic             v;
  logic             z;

  // Producer of operands and consumer of results.
  modport master (
    output in_valid, a, b, bi,
`ifdef CLA_SUB_ADD_MODE_EN
    output sub,
`endif
    output out_ready,
    input  in_ready, out_valid, d, bo, v, z
  );

  // The arithmetic unit itself.
  modport slave (
    input  in_valid, a, b, bi,
`ifdef CLA_SUB_ADD_MODE_EN
    input  sub,
`endif
    input  out_ready,
    output in_ready, out_valid, d, bo, v, z
  );
endinterface

// File: rtl/cla_sub32_pipe.sv
// Two-stage pipelined carry-lookahead subtractor: d = a - b - bi.
// Stage 1 resolves the low half, stage 2 the high half, both with the
// same group generate/propagate lookahead as the library adder, fed with
// inverted b and inverted borrow. Elastic valid/ready between stages.
// Optional macro CLA_SUB_ADD_MODE_EN adds a `sub` select (0 = add).
module cla_sub32_pipe #(
  parameter int WIDTH = 32,
  parameter int GROUP = 4
) (
  input logic             clk,
  input logic             rst,
  cla_sub32_pipe_if.slave io
);
  localparam int HALF = WIDTH / 2;
  localparam int NG   = HALF / GROUP;

  // Half-width two-level CLA: per-group G/P, group carries from a
  // lookahead combine, then bit carries inside each group. Returns {cout, sum}.
  function automatic logic [HALF:0] cla_half(input logic [HALF-1:0] x,
                                             input logic [HALF-1:0] y,
                                             input logic            cin);
    logic [HALF-1:0] g, p, s;
    logic [NG-1:0]   gg, gp;
    logic [NG:0]     gc;
    logic            c;
    g  = x & y;
    p  = x ^ y;
    s  = '0;
    for (int k = 0; k < NG; k++) begin
      gg[k] = 1'b0;
      gp[k] = 1'b1;
      for (int i = 0; i < GROUP; i++) begin
        gg[k] = g[k*GROUP+i] | (p[k*GROUP+i] & gg[k]);
        gp[k] = gp[k] & p[k*GROUP+i];
      end
    end
    gc[0] = cin;
    for (int k = 0; k < NG; k++) begin
      gc[k+1] = gg[k] | (gp[k] & gc[k]);
    end
    for (int k = 0; k < NG; k++) begin
      c = gc[k];
      for (int i = 0; i < GROUP; i++) begin
        s[k*GROUP+i] = p[k*GROUP+i] ^ c;
        c            = g[k*GROUP+i] | (p[k*GROUP+i] & c);
      end
    end
    return {gc[NG], s};
  endfunction

  // Pipeline state
  logic            s1_valid;
  logic [HALF-1:0] s1_dlo;
  logic            s1_c;
  logic [HALF-1:0] s1_ahi;
  logic [HALF-1:0] s1_nbhi;   // second operand high half (~b when subtracting)
`ifdef CLA_SUB_ADD_MODE_EN
  logic            s1_sub;
`endif
  logic             out_valid_q;
  logic [WIDTH-1:0] d_q;
  logic             bo_q, v_q, z_q;

  logic s2_adv, s1_adv, accept;

  assign s2_adv      = ~out_valid_q | io.out_ready;
  assign s1_adv      = ~s1_valid | s2_adv;
  assign accept      = io.in_valid & s1_adv;
  assign io.in_ready = s1_adv;

  // Stage 1 operand conditioning and low-half lookahead.
  logic [WIDTH-1:0] opb;
  logic             cin;
  logic [HALF:0]    lo_sum;
  // NOTE: every always_comb output gets a value on every path, so no latch can be inferred.
  always_comb begin
`ifdef CLA_SUB_ADD_MODE_EN
    opb = io.sub ? ~io.b  : io.b;
    cin = io.sub ? ~io.bi : io.bi;
`else
    opb = ~io.b;
    cin = ~io.bi;
`endif
    lo_sum = cla_half(io.a[HALF-1:0], opb[HALF-1:0], cin);
  end

  // Stage 1 register: captures low-half result and high-half operands on accept.
  // NOTE: sequential state uses non-blocking assignment so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    // NOTE: data registers are reset too, so the cleared state is fully defined, not just the valids.
    if (rst) begin
      s1_valid <= 1'b0;
      s1_dlo   <= '0;
      s1_c     <= 1'b0;
      s1_ahi   <= '0;
      s1_nbhi  <= '0;
`ifdef CLA_SUB_ADD_MODE_EN
      s1_sub   <= 1'b0;
`endif
    end else if (s1_adv) begin
      s1_valid <= io.in_valid;
      if (io.in_valid) begin
        s1_dlo  <= lo_sum[HALF-1:0];
        s1_c    <= lo_sum[HALF];
        s1_ahi  <= io.a[WIDTH-1:HALF];
        s1_nbhi <= opb[WIDTH-1:HALF];
`ifdef CLA_SUB_ADD_MODE_EN
        s1_sub  <= io.sub;
`endif
      end
    end
  end

  // Stage 2 high-half lookahead and flag derivation.
  logic [HALF:0]    hi_sum;
  logic [WIDTH-1:0] diff;
  logic             borrow, ovf;
  always_comb begin
    hi_sum = cla_half(s1_ahi, s1_nbhi, s1_c);
    diff   = {hi_sum[HALF-1:0], s1_dlo};
`ifdef CLA_SUB_ADD_MODE_EN
    borrow = s1_sub ? ~hi_sum[HALF] : hi_sum[HALF];
`else
    borrow = ~hi_sum[HALF];
`endif
    // Overflow when both effective operands share a sign that the result lacks;
    // s1_nbhi already holds the effective (possibly inverted) second operand.
    ovf = (s1_ahi[HALF-1] ~^ s1_nbhi[HALF-1]) & (diff[WIDTH-1] ^ s1_ahi[HALF-1]);
  end

  // Stage 2 register: result holds while stalled, bubbles clear out_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      d_q         <= '0;
      bo_q        <= 1'b0;
      v_q         <= 1'b0;
      z_q         <= 1'b0;
    end else if (s2_adv) begin
      out_valid_q <= s1_valid;
      if (s1_valid) begin
        d_q  <= diff;
        bo_q <= borrow;
        v_q  <= ovf;
        z_q  <= ~|diff;
      end
    end
  end

  assign io.out_valid = out_valid_q;
  assign io.d         = d_q;
  assign io.bo        = bo_q;
  assign io.v         = v_q;
  assign io.z         = z_q;
endmodule

// File: tb/tb_cla_sub32_pipe.sv
// Self-checking bench for cla_sub32_pipe: arithmetic reference model with an
// expected-result queue, one negedge compare process, and directed vectors
// with literal expectations. Build with CLA_SUB_ADD_MODE_EN to cover add mode.
module tb_cla_sub32_pipe;
  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cla_sub32_pipe_if #(.WIDTH(WIDTH)) io ();
  cla_sub32_pipe #(.WIDTH(WIDTH), .GROUP(4)) dut (.clk(clk), .rst(rst), .io(io));

  typedef struct packed {
    logic [31:0] d;
    logic        bo;
    logic        v;
    logic        z;
  } res_t;

  res_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  logic cur_sub;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain wide integer arithmetic, unsigned for d/bo, signed for v.
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic bi, input logic sub);
    longint ua, ub, sa, sb, lb, ur, sr;
    res_t   r;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    lb = longint'(bi);
    if (sub) begin
      ur   = ua - ub - lb;
      sr   = sa - sb - lb;
      r.bo = (ur < 0);
    end else begin
      ur   = ua + ub + lb;
      sr   = sa + sb + lb;
      r.bo = (ur > 64'sh0_FFFF_FFFF);
    end
    r.d = ur[31:0];
    r.v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    r.z = (r.d == 32'd0);
    return r;
  endfunction

`ifdef CLA_SUB_ADD_MODE_EN
  always_comb cur_sub = io.sub;
`else
  always_comb cur_sub = 1'b1;
`endif

  // Compare process: checks every valid output cycle and stall stability,
  // then advances the scoreboard for the coming edge.
  logic [34:0] held;
  logic        stalled = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      stalled = 1'b0;
    end else begin
      if (io.out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out_valid", 64'(io.out_valid), 64'd0);
        end else begin
          check("model_d",  64'(io.d),  64'(exp_q[0].d));
          check("model_bo", 64'(io.bo), 64'(exp_q[0].bo));
          check("model_v",  64'(io.v),  64'(exp_q[0].v));
          check("model_z",  64'(io.z),  64'(exp_q[0].z));
        end
      end
      if (stalled) begin
        check("hold_valid", 64'(io.out_valid), 64'd1);
        check("hold_data",  64'({io.d, io.bo, io.v, io.z}), 64'(held));
      end
      stalled = io.out_valid & ~io.out_ready;
      held    = {io.d, io.bo, io.v, io.z};
      if (io.out_valid && io.out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      if (io.in_valid && io.in_ready) exp_q.push_back(model(io.a, io.b, io.bi, cur_sub));
    end
  end

  task automatic set_sub(input logic s);
`ifdef CLA_SUB_ADD_MODE_EN
    io.sub = s;
`else
    if (s !== 1'b1) $display("note: add mode not built in");
`endif
  endtask

  // One isolated op with literal expectations; called just after an edge.
  task automatic send_one(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic bi, input logic s, input logic [31:0] ed,
                          input logic ebo, input logic ev, input logic ez);
    io.a = a; io.b = b; io.bi = bi; set_sub(s);
    io.in_valid = 1'b1; io.out_ready = 1'b1;
    @(posedge clk); #1;
    io.in_valid = 1'b0;
    check({name, "_not_yet"}, 64'(io.out_valid), 64'd0);
    @(posedge clk); #1;
    check({name, "_valid"}, 64'(io.out_valid), 64'd1);
    check({name, "_d"},  64'(io.d),  64'(ed));
    check({name, "_bo"}, 64'(io.bo), 64'(ebo));
    check({name, "_v"},  64'(io.v),  64'(ev));
    check({name, "_z"},  64'(io.z),  64'(ez));
  endtask

  task automatic rand_ops(input bit rnd_sub);
    logic [31:0] corner[4];
    corner[0] = 32'h0000_0000; corner[1] = 32'hFFFF_FFFF;
    corner[2] = 32'h8000_0000; corner[3] = 32'h7FFF_FFFF;
    io.a  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
    io.b  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
    io.bi = 1'($urandom_range(0, 1));
    set_sub(rnd_sub ? 1'($urandom_range(0, 1)) : 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    io.in_valid = 1'b0; io.out_ready = 1'b1;
    io.a = '0; io.b = '0; io.bi = 1'b0;
    set_sub(1'b1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_out_valid", 64'(io.out_valid), 64'd0);
    check("reset_in_ready",  64'(io.in_ready),  64'd1);
    check("reset_flags", 64'({io.d, io.bo, io.v, io.z}), 64'd0);

    // Directed vectors
    send_one("sub_basic",  32'h0000_000A, 32'h0000_0003, 1'b0, 1'b1, 32'h0000_0007, 1'b0, 1'b0, 1'b0);
    send_one("sub_wrap",   32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    send_one("sub_midbrw", 32'h0001_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h0000_FFFF, 1'b0, 1'b0, 1'b0);
    send_one("sub_ovf",    32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
    send_one("sub_zero",   32'h1234_5678, 32'h1234_5677, 1'b1, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b1);
`ifdef CLA_SUB_ADD_MODE_EN
    send_one("add_carry",  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
`endif

    // Eight back-to-back ops: one result per cycle, in_ready never drops.
    io.out_ready = 1'b1;
    rand_ops(1'b0); io.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (i < 7) begin
        rand_ops(1'b0);
        check("stream_in_ready", 64'(io.in_ready), 64'd1);
      end else begin
        io.in_valid = 1'b0;
      end
      if (i >= 1 && i <= 8) check("stream_out_valid", 64'(io.out_valid), 64'd1);
    end
    check("stream_drained", 64'(exp_q.size()), 64'd0);

    // Backpressure: fill two deep, then stall with stable outputs.
    io.out_ready = 1'b0; io.in_valid = 1'b1; rand_ops(1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      rand_ops(1'b0);
    end
    check("bp_in_ready",  64'(io.in_ready),  64'd0);
    check("bp_out_valid", 64'(io.out_valid), 64'd1);
    check("bp_depth",     64'(exp_q.size()), 64'd2);
    io.in_valid = 1'b0; io.out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1 check("bp_drain_empty", 64'(exp_q.size()), 64'd0);

    // Reset with both stages full discards everything in flight.
    io.out_ready = 1'b0; io.in_valid = 1'b1; rand_ops(1'b0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    io.in_valid = 1'b0;
    check("rst_out_valid", 64'(io.out_valid), 64'd0);
    check("rst_in_ready",  64'(io.in_ready),  64'd1);
    check("rst_d",         64'(io.d),         64'd0);
    io.out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1 check("rst_no_stale", 64'(io.out_valid), 64'd0);

    // Randomized traffic with random valid and backpressure.
    for (int i = 0; i < 3000; i++) begin
      io.in_valid  = ($urandom_range(0, 3) != 0);
      io.out_ready = ($urandom_range(0, 2) != 0);
      rand_ops(1'b1);
      @(posedge clk); #1;
    end
    io.in_valid = 1'b0; io.out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1 check("random_drain_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
